// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake bundle: data, status flags and the consumer ack.
// The receiver drives the master side; the consumer holds the slave side.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data;
    logic                 DataValid;
    logic                 DataAck;
    logic                 FramingError;
    logic                 ParityError;
    logic                 Overrun;

    modport master (
        output Data,
        output DataValid,
        output FramingError,
        output ParityError,
        output Overrun,
        input  DataAck
    );

    modport slave (
        input  Data,
        input  DataValid,
        input  FramingError,
        input  ParityError,
        input  Overrun,
        output DataAck
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receive stage: frames Rx on SamplingTick rising edges
// and presents each byte with error flags on a valid/ack handshake.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            Clock,
    input  logic            ResetN,
    input  logic            SamplingTick,
    input  logic            Rx,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick_meta;
    logic                 tick_s;
    logic                 tick_prev;
    logic                 tick_en;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 mismatch;
    logic                 at_last;

    assign tick_en = tick_s & ~tick_prev;
    assign at_last = (cnt == LAST);

    assign mismatch = (PARITY_EN != 0) &&
                      ((^shreg ^ par_bit) != 1'(PARITY_ODD));

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            rx_meta          <= 1'b1;
            rx_s             <= 1'b1;
            tick_meta        <= 1'b0;
            tick_s           <= 1'b0;
            tick_prev        <= 1'b0;
            state            <= IDLE;
            cnt              <= '0;
            idx              <= '0;
            shreg            <= '0;
            par_bit          <= 1'b0;
            bus.Data         <= '0;
            bus.DataValid    <= 1'b0;
            bus.FramingError <= 1'b0;
            bus.ParityError  <= 1'b0;
            bus.Overrun      <= 1'b0;
        end else begin
            rx_meta   <= Rx;
            rx_s      <= rx_meta;
            tick_meta <= SamplingTick;
            tick_s    <= tick_meta;
            tick_prev <= tick_s;

            if (bus.DataAck && bus.DataValid) begin
                bus.DataValid <= 1'b0;
                bus.Overrun   <= 1'b0;
            end

            if (tick_en) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == HALF) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (at_last) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            cnt   <= '0;
                            if (idx == IDX_LAST) begin
                                idx   <= '0;
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (at_last) begin
                            par_bit <= rx_s;
                            cnt     <= '0;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Leave at mid stop bit so a back-to-back start is seen.
                        if (at_last) begin
                            bus.Data         <= shreg;
                            bus.FramingError <= ~rx_s;
                            bus.ParityError  <= mismatch;
                            bus.DataValid    <= 1'b1;
                            if (bus.DataValid && !bus.DataAck) begin
                                bus.Overrun <= 1'b1;
                            end
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a plain-frame instance and a
// parity-enabled instance share clock, reset and SamplingTick.
module tb_uart_receiver;
    logic Clock;
    logic ResetN;
    logic SamplingTick;
    logic rx_m;
    logic rx_p;

    int n_cmp;
    int n_bad;

    logic [9:0] exp_m[$];
    logic [9:0] exp_p[$];

    uart_receiver_if #(.DATA_BITS(8)) bus_m ();
    uart_receiver_if #(.DATA_BITS(8)) bus_p ();

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (0),
        .PARITY_ODD(0)
    ) u_main (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .SamplingTick(SamplingTick),
        .Rx          (rx_m),
        .bus         (bus_m)
    );

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) u_par (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .SamplingTick(SamplingTick),
        .Rx          (rx_p),
        .bus         (bus_p)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One oversample instant: high two clocks, low two clocks.
    // With ack set, DataAck is high on the edge that acts on this tick.
    task automatic tick(input bit ack);
        SamplingTick = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        if (ack) bus_m.DataAck = 1'b1;
        SamplingTick = 1'b0;
        @(negedge Clock);
        bus_m.DataAck = 1'b0;
        @(negedge Clock);
    endtask

    task automatic send_bit(input bit sel, input bit b, input int n);
        if (sel) rx_p = b;
        else rx_m = b;
        repeat (n) tick(1'b0);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit use_par, input bit par,
                              input bit stop, input bit ack_commit);
        send_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], 16);
        if (use_par) send_bit(sel, par, 16);
        if (ack_commit) begin
            send_bit(sel, 1'b1, 8);
            tick(1'b1);
            send_bit(sel, 1'b1, 7);
        end else if (!stop) begin
            send_bit(sel, 1'b0, 9);
            send_bit(sel, 1'b1, 7);
        end else begin
            send_bit(sel, 1'b1, 16);
        end
    endtask

    task automatic ack(input bit sel);
        if (sel) bus_p.DataAck = 1'b1;
        else bus_m.DataAck = 1'b1;
        @(negedge Clock);
        bus_p.DataAck = 1'b0;
        bus_m.DataAck = 1'b0;
    endtask

    initial begin
        logic       pv;
        logic [9:0] pd;
        logic [9:0] cur;
        logic [9:0] e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge Clock);
            cur = {bus_m.Data, bus_m.FramingError, bus_m.ParityError};
            if (bus_m.DataValid && (!pv || cur != pd)) begin
                if (exp_m.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL main_unexpected: got %0h expected none", cur);
                end else begin
                    e = exp_m.pop_front();
                    chk("main_frame", 32'(cur), 32'(e));
                end
            end
            pv = bus_m.DataValid;
            pd = cur;
        end
    end

    initial begin
        logic       pv;
        logic [9:0] pd;
        logic [9:0] cur;
        logic [9:0] e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge Clock);
            cur = {bus_p.Data, bus_p.FramingError, bus_p.ParityError};
            if (bus_p.DataValid && (!pv || cur != pd)) begin
                if (exp_p.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL par_unexpected: got %0h expected none", cur);
                end else begin
                    e = exp_p.pop_front();
                    chk("par_frame", 32'(cur), 32'(e));
                end
            end
            pv = bus_p.DataValid;
            pd = cur;
        end
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        ResetN        = 1'b0;
        SamplingTick  = 1'b0;
        rx_m          = 1'b1;
        rx_p          = 1'b1;
        bus_m.DataAck = 1'b0;
        bus_p.DataAck = 1'b0;
        repeat (4) @(negedge Clock);

        chk("rst_data", 32'(bus_m.Data), 32'h0);
        chk("rst_valid", 32'(bus_m.DataValid), 32'h0);
        chk("rst_fe", 32'(bus_m.FramingError), 32'h0);
        chk("rst_pe", 32'(bus_m.ParityError), 32'h0);
        chk("rst_ovr", 32'(bus_m.Overrun), 32'h0);
        chk("rst_par_valid", 32'(bus_p.DataValid), 32'h0);
        ResetN = 1'b1;
        repeat (4) tick(1'b0);

        exp_m.push_back({8'h55, 1'b0, 1'b0});
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("v55_valid", 32'(bus_m.DataValid), 32'h1);
        ack(1'b0);
        chk("v55_ack_valid", 32'(bus_m.DataValid), 32'h0);

        send_bit(1'b0, 1'b0, 4);
        send_bit(1'b0, 1'b1, 28);
        chk("glitch_valid", 32'(bus_m.DataValid), 32'h0);
        chk("glitch_fe", 32'(bus_m.FramingError), 32'h0);

        exp_m.push_back({8'hA3, 1'b1, 1'b0});
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        ack(1'b0);
        exp_m.push_back({8'h00, 1'b0, 1'b0});
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clean_fe", 32'(bus_m.FramingError), 32'h0);
        ack(1'b0);

        exp_m.push_back({8'h11, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_m.push_back({8'h22, 1'b0, 1'b0});
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_set", 32'(bus_m.Overrun), 32'h1);
        chk("ovr_data", 32'(bus_m.Data), 32'h22);
        ack(1'b0);
        chk("ovr_ack_valid", 32'(bus_m.DataValid), 32'h0);
        chk("ovr_ack_clear", 32'(bus_m.Overrun), 32'h0);

        exp_m.push_back({8'h11, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_m.push_back({8'h22, 1'b0, 1'b0});
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ackc_valid", 32'(bus_m.DataValid), 32'h1);
        chk("ackc_ovr", 32'(bus_m.Overrun), 32'h0);
        ack(1'b0);

        exp_p.push_back({8'h07, 1'b0, 1'b0});
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("par_ok_pe", 32'(bus_p.ParityError), 32'h0);
        ack(1'b1);
        exp_p.push_back({8'h07, 1'b0, 1'b1});
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("par_bad_pe", 32'(bus_p.ParityError), 32'h1);
        ack(1'b1);
        chk("main_idle_par", 32'(bus_m.DataValid), 32'h0);

        exp_m.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 16);
        send_bit(1'b0, 1'b1, 8);
        ResetN = 1'b0;
        @(negedge Clock);
        chk("mrst_data", 32'(bus_m.Data), 32'h0);
        chk("mrst_valid", 32'(bus_m.DataValid), 32'h0);
        chk("mrst_ovr", 32'(bus_m.Overrun), 32'h0);
        ResetN = 1'b1;
        send_bit(1'b0, 1'b1, 8);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 16);
        send_bit(1'b0, 1'b1, 16);
        chk("mrst_no_commit", 32'(bus_m.DataValid), 32'h0);

        exp_m.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("v3c_valid", 32'(bus_m.DataValid), 32'h1);
        ack(1'b0);

        repeat (20) @(negedge Clock);
        chk("main_drained", 32'(exp_m.size()), 32'h0);
        chk("par_drained", 32'(exp_p.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It sits directly downstream of the baud generator and consumes its SamplingTick. SamplingTick is a level that toggles; each rising edge counts as one oversample instant. The block frames the Rx line (start, data, optional parity, stop) and presents each byte on a valid/ack handshake with error flags.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first (legal 5..8).
OVERSAMPLE, 16, SamplingTick rising edges per bit period (power of 2, 8..16).
PARITY_EN, 0, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).

Ports:
Clock  in  1  system clock; all state updates on its rising edge.
ResetN  in  1  synchronous active-low reset.
SamplingTick  in  1  oversample tick level from the baud generator.
Rx  in  1  asynchronous serial input; idles high.
Data  out  DATA_BITS  last received byte; held until the next commit.
DataValid  out  1  level; high while Data is unconsumed.
DataAck  in  1  consumer pulse; clears DataValid.
FramingError  out  1  stop bit of the last committed frame sampled 0.
ParityError  out  1  parity mismatch on the last committed frame (0 if PARITY_EN=0).
Overrun  out  1  sticky; a frame committed while DataValid was high.

Behaviour:
- Reset (ResetN=0 at a Clock edge): state IDLE, counters 0, Data=0, DataValid=0, FramingError=0, ParityError=0, Overrun=0. Rx synchronizer flops preset to 1; SamplingTick synchronizer flops cleared.
- Reset mid-frame abandons the frame; nothing is committed.
- Input conditioning:
  - Rx passes through a 2-flop synchronizer (rx_s).
  - SamplingTick passes through a 2-flop synchronizer plus a previous-value flop.
  - tick_en = synchronized rising edge, a one-Clock pulse.
  - All FSM activity below is qualified by tick_en.
- FSM states: IDLE, START, DATA, PARITY, STOP. Sample counter is log2(OVERSAMPLE) bits; bit index is 3 bits.
- IDLE:
  - tick_en with rx_s=0 -> START, counter=0.
  - A low level seen between ticks is not acted on until the next tick.
- START:
  - Each tick increments counter.
  - At counter==OVERSAMPLE/2-1 (mid start bit): if rx_s=0 -> DATA with counter=0 and index=0; else false start -> IDLE, with no flags changed.
- DATA:
  - At counter==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (shift right), counter=0, index+1.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - Samples therefore land at mid-bit.
- PARITY:
  - At counter==OVERSAMPLE-1: capture rx_s, counter=0 -> STOP.
  - Mismatch when XOR(data bits, parity bit) != PARITY_ODD.
- STOP: at counter==OVERSAMPLE-1, sample rx_s and commit on that Clock edge:
  - Data <= shift register (DATA_BITS right-justified).
  - FramingError <= ~rx_s.
  - ParityError <= mismatch.
  - DataValid <= 1.
  - Return to IDLE at mid stop bit so a back-to-back start bit is caught.
- Frames with errors are still committed; the flags describe that frame.
- Handshake:
  - DataAck while DataValid=1 clears DataValid on the next edge.
  - DataAck while DataValid=0 is ignored.
- Commit while DataValid=1 and DataAck=0: Overrun <= 1. The new frame still overwrites Data and the flags (newest wins).
- Commit and DataAck in the same cycle: DataValid stays 1 with the new data; no Overrun.
- Overrun clears only on DataAck with no simultaneous overrun condition, or on reset.
- Latency: DataValid rises exactly one Clock after the tick_en that samples the stop bit. Total frame = (1+DATA_BITS+PARITY_EN)·OVERSAMPLE + OVERSAMPLE/2 ticks from the first low-detect tick, within ±1 tick of detect jitter.
- Counter and index never wrap in use: both reset to 0 on every state change.

Test Plan:
- Default params, Rx drives 0x55 (start, 1010 1010 LSB first, stop=1) at 16 ticks/bit -> DataValid=1 and Data=0x55, no error flags; DataAck -> DataValid=0 next cycle.
- Rx low for 4 ticks then high (glitch) -> FSM returns to IDLE at mid-start; DataValid stays 0, no flags.
- Frame 0xA3 with stop bit 0 -> Data=0xA3, DataValid=1, FramingError=1; next clean frame 0x00 -> FramingError=0.
- Frames 0x11 then 0x22 back-to-back, no DataAck -> Data=0x22, Overrun=1; DataAck -> DataValid=0 and Overrun=0. Repeat with DataAck landing on the commit cycle of 0x22 -> Overrun stays 0.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity 1 -> ParityError=0; same frame with parity 0 -> ParityError=1.
- ResetN=0 for one Clock during bit 4 of a frame -> all outputs 0 next edge. Remaining bits then ignored (stop-bit high returns the line to idle), no commit; a following 0x3C frame is received correctly.
